// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the clk_en_gen clock-enable generator.
package clk_en_pkg;

    typedef enum logic {
        LOCKING = 1'b0,
        LOCKED  = 1'b1
    } lock_state_t;

    localparam int CLK_EN_MAX_CH = 16;

    // A programmed ratio of 0 would never wrap; treat it as divide-by-1.
    function automatic logic [31:0] norm_ratio(input logic [31:0] r);
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/clk_en_div_ch.sv
// One divider channel: shadow/active ratio, wrap counter, registered ce strobe and tick.
module clk_en_div_ch
    import clk_en_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             run,
    input  logic             align,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] cfg,
    output logic             ce,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] shadow_nxt;
    logic             wrap;

    // A load in the same cycle as a wrap or idle update is picked up directly.
    assign shadow_nxt = cfg_load ? DIV_W'(norm_ratio(32'(cfg))) : shadow;
    assign wrap       = (cnt == active - ONE);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cnt    <= '0;
            active <= ONE;
            shadow <= ONE;
            ce     <= 1'b0;
            tick   <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (!run || align) begin
                cnt    <= '0;
                ce     <= 1'b0;
                tick   <= 1'b0;
                active <= shadow_nxt;
            end else if (wrap) begin
                cnt    <= '0;
                ce     <= 1'b1;
                tick   <= ~tick;
                active <= shadow_nxt;
            end else begin
                cnt <= cnt + ONE;
                ce  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator with lock sequencer.
// Optional phase alignment on align_in when CLK_EN_GEN_PHASE_ALIGN_EN is defined.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 15
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    relock_req,
    input  logic                    align_in,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       tick_out,
    output logic                    locked
);

    localparam int CNT_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    lock_state_t      state;
    lock_state_t      state_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;
    logic             run_ok;
    logic             align_ok;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state    <= LOCKING;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            LOCKING: begin
                if (relock_req)
                    lock_cnt_nxt = '0;
                else if (lock_cnt == LOCK_MAX)
                    state_nxt = LOCKED;
                else
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
            LOCKED: begin
                if (relock_req) begin
                    state_nxt    = LOCKING;
                    lock_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = LOCKING;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // A relock pulse must clear the channels on the same edge the FSM leaves LOCKED.
    always_comb begin
        locked = (state == LOCKED);
        run_ok = locked & ~relock_req;
    end

`ifdef CLK_EN_GEN_PHASE_ALIGN_EN
    assign align_ok = run_ok & align_in;
`else
    logic unused_align;
    assign unused_align = align_in;
    assign align_ok     = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_div_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk_in  (clk_in),
            .reset_in(reset_in),
            .run     (run_ok & ch_en[i]),
            .align   (align_ok),
            .cfg_load(cfg_load),
            .cfg     (div_cfg[i*DIV_W +: DIV_W]),
            .ce      (ce_out[i]),
            .tick    (tick_out[i])
        );
    end

endmodule
